unary_reduce_scheduler: RTL and testbench



---
 rtl/unary_reduce_scheduler_pkg.sv | 21 ++
 rtl/unary_reduce_scheduler_if.sv | 28 ++
 rtl/unary_reduce_scheduler_reduce_unit.sv | 35 +++
 rtl/unary_reduce_scheduler.sv | 121 ++++++++++++
 tb/tb_unary_reduce_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unary_reduce_scheduler_pkg.sv
// Shared types for the unary reduction scheduler: opcode and FSM state encodings.
package unary_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } unary_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam logic [2:0] OP_MAX_LEGAL = 3'd5;

endpackage

// File: rtl/unary_reduce_scheduler_if.sv
// Request/response bundle between M requesters, the scheduler and the result consumer.
interface unary_reduce_scheduler_if #(
    parameter int N = 8,
    parameter int M = 4
);
    localparam int ID_W = $clog2(M);

    logic [M-1:0]    req_valid;
    logic [M-1:0]    req_ready;
    logic [M*N-1:0]  req_data;
    logic [M*3-1:0]  req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_data;
    logic [ID_W-1:0] rsp_id;
    logic            rsp_err;

    modport master (
        output req_valid, req_data, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_data, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

endinterface

// File: rtl/unary_reduce_scheduler_reduce_unit.sv
// Combinational N-bit unary reducer; illegal opcodes yield result 0 with illegal set.
module unary_reduce_unit
    import unary_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] operand,
    input  logic [2:0]   op,
    output logic         result,
    output logic         illegal
);

    logic red_and;
    logic red_or;
    logic red_xor;

    assign red_and = &operand;
    assign red_or  = |operand;
    assign red_xor = ^operand;

    always_comb begin
        result  = 1'b0;
        illegal = (op > OP_MAX_LEGAL);
        case (op)
            OP_AND:  result = red_and;
            OP_NAND: result = ~red_and;
            OP_OR:   result = red_or;
            OP_NOR:  result = ~red_or;
            OP_XOR:  result = red_xor;
            OP_XNOR: result = ~red_xor;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/unary_reduce_scheduler.sv
// Round-robin scheduler sharing one unary reducer among M requesters (accept, execute, respond).
module unary_reduce_scheduler
    import unary_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    unary_reduce_scheduler_if.slave bus,
    output logic                   busy
);

    localparam int ID_W = $clog2(M);

    sched_state_e    state, state_nx;
    logic [ID_W-1:0] ptr, grant, ptr_nx;
    logic [N-1:0]    data_q, sel_data;
    logic [2:0]      op_q, sel_op;
    logic [ID_W-1:0] id_q;
    logic            rsp_data_q, rsp_err_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [M-1:0]    req_ready_c;
    logic            grant_fire;
    logic            red_result, red_illegal;

    // First valid requester at or above ptr, wrapping modulo M.
    function automatic logic [ID_W-1:0] rr_pick(input logic [M-1:0] v, input logic [ID_W-1:0] p);
        logic [ID_W-1:0] g;
        logic            found;
        int              idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < M; k++) begin
            idx = (int'(p) + k) % M;
            if (!found && v[idx]) begin
                g     = ID_W'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    assign grant  = rr_pick(bus.req_valid, ptr);
    assign ptr_nx = (grant == ID_W'(M - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        sel_data = '0;
        sel_op   = '0;
        for (int i = 0; i < M; i++) begin
            if (ID_W'(i) == grant) begin
                sel_data = bus.req_data[i*N +: N];
                sel_op   = bus.req_op[i*3 +: 3];
            end
        end
    end

    unary_reduce_unit #(.N(N)) u_reduce (
        .operand (data_q),
        .op      (op_q),
        .result  (red_result),
        .illegal (red_illegal)
    );

    always_comb begin
        state_nx    = state;
        req_ready_c = '0;
        grant_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready_c[grant] = 1'b1;
                    grant_fire         = 1'b1;
                    state_nx           = EXEC;
                end
            end
            EXEC:    state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Nothing may be granted while reset is held, whatever the state register says.
        if (!rst_n) begin
            req_ready_c = '0;
            grant_fire  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            data_q     <= '0;
            op_q       <= '0;
            id_q       <= '0;
            rsp_data_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            state <= state_nx;
            if (grant_fire) begin
                data_q <= sel_data;
                op_q   <= sel_op;
                id_q   <= grant;
                ptr    <= ptr_nx;
            end
            if (state == EXEC) begin
                rsp_data_q <= red_result;
                rsp_err_q  <= red_illegal;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state == RESP) && rst_n;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state != IDLE) && rst_n;

endmodule

// File: tb/tb_unary_reduce_scheduler.sv
// Bench for unary_reduce_scheduler: directed vector table, corner sequences, randomized model check.
module tb_unary_reduce_scheduler;

    localparam int N = 8;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    unary_reduce_scheduler_if #(.N(N), .M(M)) bus ();

    unary_reduce_scheduler #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [2:0] op;
        logic       exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] op);
        bus.req_data[i*N +: N] = d;
        bus.req_op[i*3 +: 3]   = op;
    endtask

    function automatic logic [M-1:0] onehot(input int i);
        logic [M-1:0] m;
        m    = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    // Reference result from population count rather than reduction operators.
    function automatic logic model_result(input logic [2:0] op, input logic [7:0] d);
        int ones;
        ones = $countones(d);
        case (op)
            3'd0:    return ones == N;
            3'd1:    return ones != N;
            3'd2:    return ones > 0;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        set_req(v.id, v.data, v.op);
        bus.req_valid = onehot(v.id);
        #1;
        check("vec_req_ready", 32'(bus.req_ready), 32'(onehot(v.id)));
        tick();
        bus.req_valid = '0;
        #1;
        check("vec_exec_ready", 32'(bus.req_ready), 32'd0);
        check("vec_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("vec_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("vec_rsp_data", 32'(bus.rsp_data), 32'(v.exp_data));
        check("vec_rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
        check("vec_rsp_id", 32'(bus.rsp_id), 32'(v.id));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        check("vec_back_idle", {30'd0, bus.rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        int         ptr_m;
        int         g;
        int         waits;
        logic [M-1:0] mask;
        logic [7:0] d_m[M];
        logic [2:0] op_m[M];
        logic       held_data;

        vecs[0] = '{0, 8'hFF, 3'd1, 1'b0, 1'b0};
        vecs[1] = '{2, 8'hA5, 3'd6, 1'b0, 1'b1};
        vecs[2] = '{1, 8'h07, 3'd4, 1'b1, 1'b0};
        vecs[3] = '{1, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[4] = '{1, 8'h00, 3'd3, 1'b1, 1'b0};
        vecs[5] = '{1, 8'hFF, 3'd0, 1'b1, 1'b0};
        vecs[6] = '{1, 8'h03, 3'd5, 1'b1, 1'b0};
        vecs[7] = '{3, 8'h80, 3'd7, 1'b0, 1'b1};
        vecs[8] = '{3, 8'hE5, 3'd4, 1'b1, 1'b0};
        vecs[9] = '{0, 8'h7F, 3'd0, 1'b0, 1'b0};

        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset with every requester asserting: nothing may be granted.
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        check("rst_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_err, 2'(bus.rsp_id)}, 32'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Round robin with all requesters held valid.
        do_reset();
        for (int i = 0; i < M; i++) set_req(i, 8'(i * 8'h11 + 8'h01), 3'd4);
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", 32'(bus.req_ready), 32'(onehot(k % M)));
            tick();
            tick();
            check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("rr_rsp_id", 32'(bus.rsp_id), 32'(k % M));
            check("rr_rsp_data", 32'(bus.rsp_data), 32'(model_result(3'd4, 8'((k % M) * 8'h11 + 8'h01))));
            tick();
        end
        bus.rsp_ready = 1'b0;

        // Response held while the consumer stalls (next grant goes to requester 1).
        set_req(1, 8'hFF, 3'd0);
        #1;
        check("hold_grant", 32'(bus.req_ready), 32'(onehot(1)));
        tick();
        tick();
        held_data = bus.rsp_data;
        check("hold_data0", 32'(held_data), 32'd1);
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_data", 32'(bus.rsp_data), 32'(held_data));
            check("hold_id", 32'(bus.rsp_id), 32'd1);
            check("hold_ready", 32'(bus.req_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Accept (grant 2), reset while in EXEC, then the first grant must go to 0.
        #1;
        check("pre_rst_grant", 32'(bus.req_ready), 32'(onehot(2)));
        tick();
        check("in_exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_grant0", 32'(bus.req_ready), 32'(onehot(0)));
        tick();
        tick();
        check("rst_exec_rsp_id", 32'(bus.rsp_id), 32'd0);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        ptr_m = 0;
        for (int t = 0; t < 80; t++) begin
            mask = M'($urandom_range(0, (1 << M) - 1));
            for (int i = 0; i < M; i++) begin
                d_m[i]  = 8'($urandom);
                op_m[i] = 3'($urandom_range(0, 7));
                set_req(i, d_m[i], op_m[i]);
            end
            bus.req_valid = mask;
            #1;
            if (mask == '0) begin
                check("rnd_no_grant", 32'(bus.req_ready), 32'd0);
                tick();
                check("rnd_stay_idle", 32'(busy), 32'd0);
                continue;
            end
            g = -1;
            for (int k = 0; k < M && g < 0; k++)
                if (mask[(ptr_m + k) % M]) g = (ptr_m + k) % M;
            check("rnd_grant", 32'(bus.req_ready), 32'(onehot(g)));
            tick();
            bus.req_valid = M'($urandom);
            tick();
            waits = $urandom_range(0, 3);
            for (int w = 0; w <= waits; w++) begin
                check("rnd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("rnd_rsp_id", 32'(bus.rsp_id), 32'(g));
                check("rnd_rsp_data", 32'(bus.rsp_data), 32'(model_result(op_m[g], d_m[g])));
                check("rnd_rsp_err", 32'(bus.rsp_err), 32'(op_m[g] > 3'd5));
                if (w < waits) tick();
            end
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            bus.req_valid = '0;
            #1;
            check("rnd_back_idle", 32'(busy), 32'd0);
            ptr_m = (g + 1) % M;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
